eth_frame_filter: RTL

- Store-and-forward filter directly downstream of the Ethernet frame parser.
- Buffers each incoming AXI4-Stream frame in a data FIFO. When the last beat arrives, it applies configurable drop rules using the eth_metadata_t delivered with that beat.
- Accepted frames are then released with their metadata held on m_axis_tuser for the whole frame. Rejected frames are discarded by rolling back the write pointer.
- Keeps accept/drop statistics.

---
 rtl/eth_parser_pkg.sv | 38 +++
 rtl/eth_filter_meta_fifo.sv | 43 ++++
 rtl/eth_frame_filter.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/eth_parser_pkg.sv
// Parser/filter shared types: frame metadata, filter FSM states, drop-rule helper.
package eth_parser_pkg;

  localparam int MAC_MCAST_BIT = 40;

  typedef struct packed {
    logic [47:0] dest_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
    logic        vlan_present;
    logic [11:0] vlan_id;
    logic        is_unknown;
  } eth_metadata_t;

  typedef enum logic {
    FS_STORE   = 1'b0,
    FS_DISCARD = 1'b1
  } filt_state_t;

  // Group-addressed destinations (multicast/broadcast) always pass the MAC check.
  function automatic logic filt_drop(
    input eth_metadata_t meta,
    input logic          meta_vld,
    input logic [47:0]   local_mac,
    input logic          promisc,
    input logic          drop_unknown,
    input logic          vlan_en,
    input logic [11:0]   vlan_id
  );
    logic drop;
    drop = !meta_vld;
    if (drop_unknown && meta.is_unknown) drop = 1'b1;
    if (vlan_en && (!meta.vlan_present || meta.vlan_id != vlan_id)) drop = 1'b1;
    if (!promisc && meta.dest_mac != local_mac && !meta.dest_mac[MAC_MCAST_BIT]) drop = 1'b1;
    return drop;
  endfunction

endpackage

// File: rtl/eth_filter_meta_fifo.sv
// Purpose: FWFT FIFO of per-frame metadata for committed frames.
// Latency: a push is visible at head the following cycle.
// Backpressure: full/empty flags only; pushes while full and pops while empty are ignored.
module eth_filter_meta_fifo
  import eth_parser_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  eth_metadata_t push_dat,
  input  logic          pop,
  output eth_metadata_t head,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  eth_metadata_t mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/eth_frame_filter.sv
// Purpose: store-and-forward frame filter; drops by MAC/VLAN/unknown rules, rolls back rejected frames.
// Latency: tlast accepted at cycle N into an empty block -> first m_axis_tvalid at N+2.
// Backpressure: s_axis_tready low when data FIFO full with committed frames pending or meta FIFO full.
module eth_frame_filter
  import eth_parser_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 256,
  parameter int META_DEPTH = 8,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  eth_metadata_t         s_axis_tuser,
  input  logic                  s_axis_tuser_valid,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output eth_metadata_t         m_axis_tuser,
  input  logic [47:0]           cfg_local_mac,
  input  logic                  cfg_promisc,
  input  logic                  cfg_drop_unknown,
  input  logic                  cfg_vlan_en,
  input  logic [11:0]           cfg_vlan_id,
  output logic [CNT_WIDTH-1:0]  stat_accepted,
  output logic [CNT_WIDTH-1:0]  stat_dropped,
  output logic [CNT_WIDTH-1:0]  stat_oversize
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH:0] mem [FIFO_DEPTH];
  logic [AW:0]         wr_ptr;
  logic [AW:0]         commit_ptr;
  logic [AW:0]         rd_ptr;
  logic [AW:0]         wr_ptr_inc;
  logic [DATA_WIDTH:0] rd_word;

  filt_state_t   state;
  filt_state_t   state_nxt;
  eth_metadata_t meta_head;
  logic          meta_full;
  logic          meta_empty;
  logic          meta_pop;

  logic in_fire;
  logic data_full;
  logic write_fills;
  logic oversize;
  logic store_beat;
  logic decide;
  logic keep;
  logic can_read;
  logic rd_fire;
  logic out_vld;
  logic out_last;
  logic [DATA_WIDTH-1:0] out_dat;

  assign in_fire     = s_axis_tvalid && s_axis_tready;
  assign wr_ptr_inc  = wr_ptr + 1'b1;
  assign data_full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign write_fills = (wr_ptr_inc[AW] != rd_ptr[AW]) && (wr_ptr_inc[AW-1:0] == rd_ptr[AW-1:0]);

  // A frame that alone fills the buffer can never be committed, so it is abandoned.
  assign oversize   = (state == FS_STORE) && in_fire && write_fills && meta_empty;
  assign store_beat = (state == FS_STORE) && in_fire && !oversize;
  assign decide     = store_beat && s_axis_tlast;
  assign keep       = decide && !filt_drop(s_axis_tuser, s_axis_tuser_valid, cfg_local_mac,
                                           cfg_promisc, cfg_drop_unknown, cfg_vlan_en, cfg_vlan_id);

  always_ff @(posedge clk) begin
    if (rst) state <= FS_STORE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FS_STORE:   if (oversize && !s_axis_tlast) state_nxt = FS_DISCARD;
      FS_DISCARD: if (in_fire && s_axis_tlast)   state_nxt = FS_STORE;
      default:    state_nxt = FS_STORE;
    endcase
  end

  always_comb begin
    s_axis_tready = 1'b1;
    if (state == FS_STORE && ((data_full && !meta_empty) || meta_full)) s_axis_tready = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (store_beat) mem[wr_ptr[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr        <= '0;
      commit_ptr    <= '0;
      rd_ptr        <= '0;
      stat_accepted <= '0;
      stat_dropped  <= '0;
      stat_oversize <= '0;
    end else begin
      if (oversize) begin
        wr_ptr        <= commit_ptr;
        stat_oversize <= stat_oversize + 1'b1;
      end else if (keep) begin
        wr_ptr        <= wr_ptr_inc;
        commit_ptr    <= wr_ptr_inc;
        stat_accepted <= stat_accepted + 1'b1;
      end else if (decide) begin
        wr_ptr       <= commit_ptr;
        stat_dropped <= stat_dropped + 1'b1;
      end else if (store_beat) begin
        wr_ptr <= wr_ptr_inc;
      end
      if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign rd_word  = mem[rd_ptr[AW-1:0]];
  assign can_read = (rd_ptr != commit_ptr) && !meta_empty;
  assign rd_fire  = can_read && (!out_vld || m_axis_tready);
  assign meta_pop = out_vld && m_axis_tready && out_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      out_dat  <= '0;
    end else if (rd_fire) begin
      out_vld  <= 1'b1;
      out_last <= rd_word[DATA_WIDTH];
      out_dat  <= rd_word[DATA_WIDTH-1:0];
    end else if (m_axis_tready) begin
      out_vld <= 1'b0;
    end
  end

  eth_filter_meta_fifo #(
    .DEPTH (META_DEPTH)
  ) u_meta_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (keep),
    .push_dat (s_axis_tuser),
    .pop      (meta_pop),
    .head     (meta_head),
    .full     (meta_full),
    .empty    (meta_empty)
  );

  assign m_axis_tvalid = out_vld;
  assign m_axis_tlast  = out_last;
  assign m_axis_tdata  = out_dat;
  assign m_axis_tuser  = meta_empty ? '0 : meta_head;

endmodule
